// File: rtl/light_package.sv
// Shared light-controller types: light colors and the per-lane sensor conditioning state.
package light_package;

  typedef enum logic [1:0] {
    RED    = 2'd0,
    YELLOW = 2'd1,
    GREEN  = 2'd2
  } colors;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    QUAL    = 3'd1,
    PRESENT = 3'd2,
    HOLD    = 3'd3,
    LATCHED = 3'd4
  } lane_state_t;

  localparam int NUM_LANES = 5;

endpackage

// File: rtl/lane_conditioner.sv
// One loop-detector lane: 2-flop synchronizer, debounce/hold/latch FSM, and an optional
// stuck-detector guarded by SENSOR_FAULT_DETECT_EN.
module lane_conditioner
  import light_package::*;
#(
  parameter int DEBOUNCE_CYCLES = 3,
  parameter int HOLD_CYCLES     = 2,
  parameter int STUCK_CYCLES    = 60
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  raw,
  input  colors light,
  output logic  sensor,
  output logic  fault
);

  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 15) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES out of range 1..15");
  end
  if (HOLD_CYCLES < 1 || HOLD_CYCLES > 15) begin : g_bad_hold
    $error("HOLD_CYCLES out of range 1..15");
  end
  if (STUCK_CYCLES < 2 || STUCK_CYCLES > 255) begin : g_bad_stuck
    $error("STUCK_CYCLES out of range 2..255");
  end

  localparam logic [3:0] QMAX = 4'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0] HMAX = 4'(HOLD_CYCLES);

  logic [1:0]  sync;
  logic        s;
  lane_state_t state, state_n;
  logic [3:0]  qcnt, qcnt_n, hcnt, hcnt_n;
  logic        served, served_n, served_now, green;
  logic        fsm_sensor;

  assign s     = sync[1];
  assign green = (light == GREEN);

  always_ff @(posedge clk) begin
    if (reset) begin
      sync   <= '0;
      state  <= IDLE;
      qcnt   <= '0;
      hcnt   <= '0;
      served <= 1'b0;
    end else begin
      sync   <= {sync[0], raw};
      state  <= state_n;
      qcnt   <= qcnt_n;
      hcnt   <= hcnt_n;
      served <= served_n;
    end
  end

  // Green seen this cycle counts as service for the HOLD exit decision on the same edge.
  assign served_now = served | (((state == PRESENT) || (state == HOLD)) && green);

  always_comb begin
    state_n = state;
    qcnt_n  = qcnt;
    hcnt_n  = hcnt;
    case (state)
      IDLE: begin
        if (s) begin
          qcnt_n  = 4'd1;
          state_n = (DEBOUNCE_CYCLES == 1) ? PRESENT : QUAL;
        end
      end
      QUAL: begin
        if (!s)               state_n = IDLE;
        else if (qcnt == QMAX) state_n = PRESENT;
        else                  qcnt_n  = qcnt + 4'd1;
      end
      PRESENT: begin
        if (!s) begin
          state_n = HOLD;
          hcnt_n  = 4'd1;
        end
      end
      HOLD: begin
        if (s)                 state_n = PRESENT;
        else if (hcnt >= HMAX) state_n = served_now ? IDLE : LATCHED;
        else                   hcnt_n  = hcnt + 4'd1;
      end
      LATCHED: begin
        if (s)          state_n = PRESENT;
        else if (green) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    served_n = (state_n == IDLE) ? 1'b0 : served_now;
  end

  assign fsm_sensor = (state == PRESENT) || (state == HOLD) || (state == LATCHED);

`ifdef SENSOR_FAULT_DETECT_EN
  localparam logic [7:0] SMAX = 8'(STUCK_CYCLES - 1);

  logic [7:0] stuck_cnt;
  logic       stuck;

  always_ff @(posedge clk) begin
    if (reset) begin
      stuck_cnt <= '0;
      stuck     <= 1'b0;
    end else begin
      if (!s)                    stuck_cnt <= '0;
      else if (stuck_cnt != 8'hff) stuck_cnt <= stuck_cnt + 8'd1;
      if (s && stuck_cnt >= SMAX) stuck <= 1'b1;
    end
  end

  // A stuck loop keeps requesting so the approach is never starved.
  assign fault  = stuck;
  assign sensor = fsm_sensor | stuck;
`else
  assign fault  = 1'b0;
  assign sensor = fsm_sensor;
`endif

endmodule

// File: rtl/sensor_conditioner.sv
// Conditions five noisy loop-detector inputs into controller lane requests.
// Optional stuck-detector fault logic enabled by SENSOR_FAULT_DETECT_EN.
module sensor_conditioner
  import light_package::*;
#(
  parameter int DEBOUNCE_CYCLES = 3,
  parameter int HOLD_CYCLES     = 2,
  parameter int STUCK_CYCLES    = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       raw_e_str,
  input  logic       raw_w_str,
  input  logic       raw_e_left,
  input  logic       raw_w_left,
  input  logic       raw_ns,
  input  colors      e_str_light,
  input  colors      w_str_light,
  input  colors      e_left_light,
  input  colors      w_left_light,
  input  colors      ns_light,
  output logic       e_str_sensor,
  output logic       w_str_sensor,
  output logic       e_left_sensor,
  output logic       w_left_sensor,
  output logic       ns_sensor,
  output logic [4:0] fault
);

  logic [NUM_LANES-1:0] raw, sensor, lane_fault;
  colors                light [NUM_LANES];

  // Lane index matches the fault bit order: 4=e_str .. 0=ns.
  assign raw      = {raw_e_str, raw_w_str, raw_e_left, raw_w_left, raw_ns};
  assign light[4] = e_str_light;
  assign light[3] = w_str_light;
  assign light[2] = e_left_light;
  assign light[1] = w_left_light;
  assign light[0] = ns_light;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    lane_conditioner #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .HOLD_CYCLES    (HOLD_CYCLES),
      .STUCK_CYCLES   (STUCK_CYCLES)
    ) u_lane (
      .clk   (clk),
      .reset (reset),
      .raw   (raw[i]),
      .light (light[i]),
      .sensor(sensor[i]),
      .fault (lane_fault[i])
    );
  end

  assign {e_str_sensor, w_str_sensor, e_left_sensor, w_left_sensor, ns_sensor} = sensor;
  assign fault = lane_fault;

endmodule

// File: tb/tb_sensor_conditioner.sv
// Scoreboard bench for sensor_conditioner: expected per-lane sensor/fault values keyed by
// clock-edge number, compared on the falling edge after that rising edge.
module tb_sensor_conditioner;
  import light_package::*;

`ifdef SENSOR_FAULT_DETECT_EN
  localparam bit FD = 1'b1;
`else
  localparam bit FD = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic raw_e_str, raw_w_str, raw_e_left, raw_w_left, raw_ns;
  colors e_str_light, w_str_light, e_left_light, w_left_light, ns_light;
  logic e_str_sensor, w_str_sensor, e_left_sensor, w_left_sensor, ns_sensor;
  logic [4:0] fault;
  logic [4:0] sens_v;

  sensor_conditioner dut (
    .clk(clk), .reset(reset),
    .raw_e_str(raw_e_str), .raw_w_str(raw_w_str), .raw_e_left(raw_e_left),
    .raw_w_left(raw_w_left), .raw_ns(raw_ns),
    .e_str_light(e_str_light), .w_str_light(w_str_light), .e_left_light(e_left_light),
    .w_left_light(w_left_light), .ns_light(ns_light),
    .e_str_sensor(e_str_sensor), .w_str_sensor(w_str_sensor), .e_left_sensor(e_left_sensor),
    .w_left_sensor(w_left_sensor), .ns_sensor(ns_sensor),
    .fault(fault)
  );

  always #5 clk = ~clk;

  assign sens_v = {e_str_sensor, w_str_sensor, e_left_sensor, w_left_sensor, ns_sensor};

  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  // lane 0..4 compares one sensor bit; lane 5 compares the whole fault vector
  typedef struct {
    int         cyc;
    int         lane;
    logic [4:0] exp;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [4:0] got, input logic [4:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%b exp=%b (edge %0d)", tag, got, exp, edge_n);
    end
  endtask

  task automatic push(input int cyc, input int lane, input logic [4:0] exp, input string tag);
    exp_t e;
    int i = 0;
    e.cyc = cyc; e.lane = lane; e.exp = exp; e.tag = tag;
    while (i < sb.size() && sb[i].cyc <= cyc) i++;
    sb.insert(i, e);
  endtask

  task automatic exp_s(input int cyc, input int lane, input bit v, input string tag);
    push(cyc, lane, {4'b0, v}, tag);
  endtask

  task automatic goto(input int n);
    while (edge_n < n - 1) @(negedge clk);
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    logic [4:0] got;
    while (sb.size() > 0 && sb[0].cyc == edge_n) begin
      e   = sb.pop_front();
      got = (e.lane == 5) ? fault : {4'b0, sens_v[e.lane]};
      chk(e.tag, got, e.exp);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    {raw_e_str, raw_w_str, raw_e_left, raw_w_left, raw_ns} = '0;
    e_str_light = GREEN; w_str_light = RED; e_left_light = RED;
    w_left_light = RED;  ns_light = RED;

    for (int l = 0; l < 5; l++) exp_s(2, l, 1'b0, "rst_sensor");
    push(2, 5, 5'b0, "rst_fault");
    // served e_str: high sampled 10..29, light green
    exp_s(13, 4, 0, "srv_pre");  exp_s(14, 4, 1, "srv_on");
    exp_s(33, 4, 1, "srv_hold"); exp_s(34, 4, 0, "srv_off");
    // unserved w_left: 6-sample pulse at 20, red until 50
    exp_s(23, 1, 0, "uns_pre");   exp_s(24, 1, 1, "uns_on");
    exp_s(35, 1, 1, "uns_latch"); exp_s(49, 1, 1, "uns_wait");
    exp_s(50, 1, 0, "uns_green");
    // ns 2-sample glitch at 40, then minimal 3-sample pulse at 50
    exp_s(42, 0, 0, "glitch_a"); exp_s(43, 0, 0, "glitch_b"); exp_s(45, 0, 0, "glitch_c");
    exp_s(52, 0, 0, "q3_early"); exp_s(53, 0, 0, "q3_pre");   exp_s(54, 0, 1, "q3_on");
    exp_s(59, 0, 1, "q3_latch"); exp_s(60, 0, 0, "q3_green");
    // w_str: latched, then s=1 and green arrive on the same edge 72
    exp_s(63, 3, 0, "sim_pre");  exp_s(64, 3, 1, "sim_on");   exp_s(71, 3, 1, "sim_latch");
    exp_s(72, 3, 1, "sim_both"); exp_s(73, 3, 1, "sim_pres"); exp_s(83, 3, 1, "sim_hold");
    exp_s(84, 3, 0, "sim_off");
    // e_left held high from 100: stuck flag on the 60th sample (edge 161)
    exp_s(103, 2, 0, "stk_pre"); exp_s(104, 2, 1, "stk_on");
    push(160, 5, 5'b0, "stk_flag_pre");
    push(161, 5, FD ? 5'b00100 : 5'b0, "stk_flag");
    exp_s(185, 2, FD, "stk_failsafe");
    push(185, 5, FD ? 5'b00100 : 5'b0, "stk_sticky");
    // reset while e_str in HOLD at 213, then fresh qualification
    exp_s(204, 4, 1, "rmo_on"); exp_s(212, 4, 1, "rmo_hold"); exp_s(213, 4, 0, "rmo_rst");
    push(213, 5, 5'b0, "rmo_fault");
    exp_s(223, 4, 0, "rmo_requal_pre"); exp_s(224, 4, 1, "rmo_requal");
    // reset mid-qualification on ns at 244
    exp_s(244, 0, 0, "rmq_rst"); exp_s(248, 0, 0, "rmq_pre");
    exp_s(249, 0, 1, "rmq_on");  exp_s(249, 4, 1, "rmq_estr");

    goto(3);   reset = 1'b0;
    goto(10);  raw_e_str = 1'b1;
    goto(20);  raw_w_left = 1'b1;
    goto(26);  raw_w_left = 1'b0;
    goto(30);  raw_e_str = 1'b0;
    goto(40);  raw_ns = 1'b1;
    goto(42);  raw_ns = 1'b0;
    goto(50);  raw_ns = 1'b1; w_left_light = GREEN;
    goto(53);  raw_ns = 1'b0;
    goto(60);  ns_light = GREEN; raw_w_str = 1'b1;
    goto(64);  raw_w_str = 1'b0;
    goto(70);  raw_w_str = 1'b1;
    goto(72);  w_str_light = GREEN;
    goto(80);  raw_w_str = 1'b0;
    goto(100); raw_e_left = 1'b1;
    goto(170); e_left_light = GREEN;
    goto(175); raw_e_left = 1'b0;
    goto(200); raw_e_str = 1'b1;
    goto(210); raw_e_str = 1'b0;
    goto(213); reset = 1'b1;
    goto(214); reset = 1'b0;
    goto(220); raw_e_str = 1'b1;
    goto(240); raw_ns = 1'b1;
    goto(244); reset = 1'b1;
    goto(245); reset = 1'b0;
    goto(260);
    @(negedge clk);
    chk("sb_drain", 5'(sb.size()), 5'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
